// File: rtl/miter_cmp_monitor.sv
// Equivalence-miter monitor: compares gold/gate channel pairs per sample, with
// per-bit don't-care on gold, and records sticky flags, counts and the first failure.
//
// state | meaning
// IDLE  | waiting for arm; results hold, no sampling
// RUN   | accepting qualified samples
// HALT  | stopped after a failing sample; results hold until clear or rst
module miter_cmp_monitor #(
  parameter int WIDTH        = 1,
  parameter int CHANNELS     = 4,
  parameter int CNT_W        = 16,
  parameter int STOP_ON_FAIL = 1,
  parameter int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      arm,
  input  logic                      clear,
  input  logic                      in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_gold,
  input  logic [CHANNELS*WIDTH-1:0] in_gold_dc,
  input  logic [CHANNELS*WIDTH-1:0] in_gate,
  output logic [CHANNELS-1:0]       ch_fail,
  output logic [CHANNELS-1:0]       fail_sticky,
  output logic [CNT_W-1:0]          fail_count,
  output logic [CNT_W-1:0]          sample_count,
  output logic [CH_W-1:0]           first_ch,
  output logic [CNT_W-1:0]          first_cycle,
  output logic                      first_valid,
  output logic [1:0]                state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CHANNELS-1:0] ch_fail_q, ch_fail_d;
  logic [CHANNELS-1:0] fail_sticky_q, fail_sticky_d;
  logic [CNT_W-1:0]    fail_count_q, fail_count_d;
  logic [CNT_W-1:0]    sample_count_q, sample_count_d;
  logic [CH_W-1:0]     first_ch_q, first_ch_d;
  logic [CNT_W-1:0]    first_cycle_q, first_cycle_d;
  logic                first_valid_q, first_valid_d;

  logic [CHANNELS-1:0] fail_vec;
  logic [CH_W-1:0]     low_idx;
  logic                any_fail;
  logic                accept;

  // A bit mismatches only when gold is not marked don't-care.
  always_comb begin
    fail_vec = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      fail_vec[c] = |((in_gold[c*WIDTH +: WIDTH] ^ in_gate[c*WIDTH +: WIDTH])
                      & ~in_gold_dc[c*WIDTH +: WIDTH]);
    end
  end

  always_comb begin
    low_idx = '0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (fail_vec[c]) low_idx = CH_W'(c);
    end
  end

  assign any_fail = |fail_vec;
  assign accept   = in_valid && (state_q == ST_RUN) && !clear;

  always_comb begin
    state_d        = state_q;
    ch_fail_d      = '0;
    fail_sticky_d  = fail_sticky_q;
    fail_count_d   = fail_count_q;
    sample_count_d = sample_count_q;
    first_ch_d     = first_ch_q;
    first_cycle_d  = first_cycle_q;
    first_valid_d  = first_valid_q;

    if (clear) begin
      state_d        = ST_IDLE;
      fail_sticky_d  = '0;
      fail_count_d   = '0;
      sample_count_d = '0;
      first_ch_d     = '0;
      first_cycle_d  = '0;
      first_valid_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (accept) begin
            ch_fail_d     = fail_vec;
            fail_sticky_d = fail_sticky_q | fail_vec;
            if (sample_count_q != '1) sample_count_d = sample_count_q + CNT_W'(1);
            if (any_fail) begin
              if (fail_count_q != '1) fail_count_d = fail_count_q + CNT_W'(1);
              if (!first_valid_q) begin
                first_ch_d    = low_idx;
                first_cycle_d = sample_count_q;
                first_valid_d = 1'b1;
              end
              if (STOP_ON_FAIL != 0) state_d = ST_HALT;
            end
          end
        end
        ST_HALT: begin
          state_d = ST_HALT;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      ch_fail_q      <= '0;
      fail_sticky_q  <= '0;
      fail_count_q   <= '0;
      sample_count_q <= '0;
      first_ch_q     <= '0;
      first_cycle_q  <= '0;
      first_valid_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      ch_fail_q      <= ch_fail_d;
      fail_sticky_q  <= fail_sticky_d;
      fail_count_q   <= fail_count_d;
      sample_count_q <= sample_count_d;
      first_ch_q     <= first_ch_d;
      first_cycle_q  <= first_cycle_d;
      first_valid_q  <= first_valid_d;
    end
  end

  assign ch_fail      = ch_fail_q;
  assign fail_sticky  = fail_sticky_q;
  assign fail_count   = fail_count_q;
  assign sample_count = sample_count_q;
  assign first_ch     = first_ch_q;
  assign first_cycle  = first_cycle_q;
  assign first_valid  = first_valid_q;
  assign state        = state_q;

endmodule

// File: doc/miter_cmp_monitor.md
MITER_CMP_MONITOR -- requirements
Module: miter_cmp_monitor

Interface
REQ-001 Parameter WIDTH, default 1: bits per compared channel.
REQ-002 Parameter CHANNELS, default 4: number of independent gold/gate channel pairs.
REQ-003 Parameter CNT_W, default 16: width of all counters and stamps.
REQ-004 Parameter STOP_ON_FAIL, default 1: 1 = halt sampling on first failing sample; 0 = keep running.
REQ-005 Parameter CH_W, default max(1, clog2(CHANNELS)): channel index width.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 arm  in  1  start checking (IDLE -> RUN).
REQ-009 clear  in  1  synchronous clear of all results, return to IDLE.
REQ-010 in_valid  in  1  sample qualifier.
REQ-011 in_gold  in  CHANNELS*WIDTH  gold values; channel c at bits [c*WIDTH +: WIDTH].
REQ-012 in_gold_dc  in  CHANNELS*WIDTH  per-bit don't-care mask for gold (hardware stand-in for gold X).
REQ-013 in_gate  in  CHANNELS*WIDTH  gate values, same packing.
REQ-014 ch_fail  out  CHANNELS  per-channel fail pulse for the last accepted sample.
REQ-015 fail_sticky  out  CHANNELS  per-channel sticky fail flags.
REQ-016 fail_count  out  CNT_W  saturating count of failing samples.
REQ-017 sample_count  out  CNT_W  saturating count of accepted samples.
REQ-018 first_ch  out  CH_W  lowest failing channel of the first failing sample.
REQ-019 first_cycle  out  CNT_W  sample index of the first failing sample.
REQ-020 first_valid  out  1  first_ch/first_cycle hold a capture.
REQ-021 state  out  2  0 = IDLE, 1 = RUN, 2 = HALT; 3 is never produced.

Function
REQ-022 Bit ok SHALL be in_gold_dc=1 or in_gold=in_gate; channel fails if any of its WIDTH bits is not ok.
REQ-023 A sample SHALL be accepted only when in_valid=1, state=RUN and clear=0 at the rising edge.
REQ-024 All outputs SHALL be registered; effect of an accepted sample is visible exactly 1 cycle after acceptance.
REQ-025 ch_fail SHALL equal the channel fail vector for one cycle after an accepted sample, else 0.
REQ-026 fail_sticky SHALL OR in ch_fail vector of every accepted sample.
REQ-027 sample_count SHALL increment by 1 per accepted sample and saturate at 2^CNT_W-1.
REQ-028 fail_count SHALL increment by 1 per accepted sample with any channel failing (not per channel), saturating at 2^CNT_W-1.
REQ-029 On the first accepted failing sample while first_valid=0: first_ch = lowest failing index, first_cycle = sample_count before increment, first_valid=1; later failures SHALL NOT overwrite.
REQ-030 FSM: IDLE->RUN on arm; RUN->HALT on accepted failing sample iff STOP_ON_FAIL=1; HALT exits only via clear or rst.
REQ-031 arm in RUN or HALT SHALL be ignored; in_valid in the arm cycle in IDLE SHALL NOT be accepted.
REQ-032 clear SHALL have priority over arm and sample acceptance in the same cycle: state IDLE, all counters, flags, captures zero next cycle.
REQ-033 In HALT and IDLE, counters, sticky flags and captures SHALL hold; ch_fail SHALL be 0.

Reset
REQ-034 rst=1 SHALL immediately, without clock, force state=IDLE and every output to 0.
REQ-035 rst deasserted SHALL leave block in IDLE until arm; a sample in flight at reset SHALL be discarded.

Verification
REQ-036 CHANNELS=4, WIDTH=8: rst, arm, 3 all-matching valid samples -> sample_count=3, fail_count=0, ch_fail=0, fail_sticky=0, state=1.
REQ-037 Then sample 3 with ch2 gold=0x5A gate=0x5B, dc=0 -> next cycle ch_fail=4'b0100, first_ch=2, first_cycle=3, first_valid=1, state=2; 2 further valid samples leave sample_count=4.
REQ-038 Same mismatch with ch2 dc=0x01 -> ch_fail=0, fail_count=0, state stays 1.
REQ-039 STOP_ON_FAIL=0, CNT_W=4: 20 samples failing on ch1 and ch3 -> fail_count=15, sample_count=15, first_ch=1, first_cycle=0, fail_sticky=4'b1010, state=1.
REQ-040 In HALT assert clear and arm together -> next cycle state=0 and all outputs 0; arm next cycle -> state=1.
REQ-041 rst pulsed between clock edges in RUN with sample_count=7 -> outputs 0 before next edge; valid sample on first post-reset edge not counted.
